// File: rtl/sobel_tap_sequencer.sv
// Sequences one 3x3 window through an external SB_MAC16 accumulator: six Gx taps, then six Gy taps.
// Optional build macro SOBEL_MAG_EN adds the saturated |gx|+|gy| output on mag_o.
module sobel_tap_sequencer #(
    parameter int MAC_LAT = 1
) (
    input  logic        clock,
    input  logic        IRSTTOP,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [71:0] win_i,
    output logic [15:0] mac_a,
    output logic [15:0] mac_b,
    output logic [15:0] mac_c,
    output logic        mac_oload,
    output logic        mac_sub,
    output logic        mac_ohold,
    input  logic [15:0] mac_o,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] gx_o,
    output logic [15:0] gy_o,
    output logic [7:0]  mag_o,
    output logic [2:0]  dbg_state_o
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        CLR_X   = 3'd1,
        TAP_X   = 3'd2,
        DRAIN_X = 3'd3,
        CLR_Y   = 3'd4,
        TAP_Y   = 3'd5,
        DRAIN_Y = 3'd6,
        OUT     = 3'd7
    } state_t;

    localparam logic [2:0] TAP_LAST   = 3'd5;
    localparam logic [2:0] DRAIN_LAST = 3'(MAC_LAT - 1);

    state_t      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [71:0] win_q, win_d;
    logic [15:0] gx_q, gx_d;
    logic [15:0] gy_q, gy_d;
    logic        gy_cap;

    logic [3:0]  pix_idx;
    logic [1:0]  coef_mag;
    logic        coef_neg;
    logic [7:0]  pix;

    // Tap tables: pixel index 3*r+c, coefficient magnitude and sign.
    always_comb begin
        pix_idx  = 4'd0;
        coef_mag = 2'd1;
        coef_neg = 1'b0;
        if (state_q == TAP_Y) begin
            case (cnt_q)
                3'd0:    begin pix_idx = 4'd0; coef_mag = 2'd1; coef_neg = 1'b1; end
                3'd1:    begin pix_idx = 4'd1; coef_mag = 2'd2; coef_neg = 1'b1; end
                3'd2:    begin pix_idx = 4'd2; coef_mag = 2'd1; coef_neg = 1'b1; end
                3'd3:    begin pix_idx = 4'd6; coef_mag = 2'd1; coef_neg = 1'b0; end
                3'd4:    begin pix_idx = 4'd7; coef_mag = 2'd2; coef_neg = 1'b0; end
                default: begin pix_idx = 4'd8; coef_mag = 2'd1; coef_neg = 1'b0; end
            endcase
        end else begin
            case (cnt_q)
                3'd0:    begin pix_idx = 4'd0; coef_mag = 2'd1; coef_neg = 1'b1; end
                3'd1:    begin pix_idx = 4'd2; coef_mag = 2'd1; coef_neg = 1'b0; end
                3'd2:    begin pix_idx = 4'd3; coef_mag = 2'd2; coef_neg = 1'b1; end
                3'd3:    begin pix_idx = 4'd5; coef_mag = 2'd2; coef_neg = 1'b0; end
                3'd4:    begin pix_idx = 4'd6; coef_mag = 2'd1; coef_neg = 1'b1; end
                default: begin pix_idx = 4'd8; coef_mag = 2'd1; coef_neg = 1'b0; end
            endcase
        end
    end

    assign pix = win_q[{pix_idx, 3'b000} +: 8];

    // Handshakes: a transfer happens on a rising edge where valid & ready are both high;
    // in_ready is high only in IDLE, out_valid only in OUT, and OUT data is held until taken.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        win_d     = win_q;
        gx_d      = gx_q;
        gy_d      = gy_q;
        gy_cap    = 1'b0;
        mac_a     = 16'd0;
        mac_b     = 16'd0;
        mac_oload = 1'b0;
        mac_sub   = 1'b0;
        mac_ohold = 1'b1;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    win_d   = win_i;
                    cnt_d   = 3'd0;
                    state_d = CLR_X;
                end
            end
            CLR_X, CLR_Y: begin
                mac_oload = 1'b1;
                mac_ohold = 1'b0;
                cnt_d     = 3'd0;
                state_d   = (state_q == CLR_X) ? TAP_X : TAP_Y;
            end
            TAP_X, TAP_Y: begin
                mac_ohold = 1'b0;
                mac_a     = {8'd0, pix};
                mac_b     = {14'd0, coef_mag};
                mac_sub   = coef_neg;
                if (cnt_q == TAP_LAST) begin
                    cnt_d   = 3'd0;
                    state_d = (state_q == TAP_X) ? DRAIN_X : DRAIN_Y;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            DRAIN_X, DRAIN_Y: begin
                if (cnt_q == DRAIN_LAST) begin
                    cnt_d = 3'd0;
                    if (state_q == DRAIN_X) begin
                        gx_d    = mac_o;
                        state_d = CLR_Y;
                    end else begin
                        gy_d    = mac_o;
                        gy_cap  = 1'b1;
                        state_d = OUT;
                    end
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            OUT: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge IRSTTOP) begin
        if (IRSTTOP) begin
            state_q <= IDLE;
            cnt_q   <= 3'd0;
            win_q   <= 72'd0;
            gx_q    <= 16'd0;
            gy_q    <= 16'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            win_q   <= win_d;
            gx_q    <= gx_d;
            gy_q    <= gy_d;
        end
    end

`ifdef SOBEL_MAG_EN
    logic [15:0] abs_gx, abs_gy;
    logic [16:0] mag_sum;
    logic [7:0]  mag_d, mag_q;

    // gx is already registered; gy is taken straight from the accumulator in the same cycle.
    always_comb begin
        abs_gx  = gx_q[15] ? (16'd0 - gx_q) : gx_q;
        abs_gy  = mac_o[15] ? (16'd0 - mac_o) : mac_o;
        mag_sum = {1'b0, abs_gx} + {1'b0, abs_gy};
        mag_d   = mag_q;
        if (gy_cap) mag_d = (|mag_sum[16:8]) ? 8'hFF : mag_sum[7:0];
    end

    always_ff @(posedge clock or posedge IRSTTOP) begin
        if (IRSTTOP) mag_q <= 8'd0;
        else         mag_q <= mag_d;
    end

    assign mag_o = mag_q;
`else
    assign mag_o = 8'd0;
`endif

    assign in_ready    = (state_q == IDLE);
    assign out_valid   = (state_q == OUT);
    assign gx_o        = gx_q;
    assign gy_o        = gy_q;
    assign mac_c       = 16'd0;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_sobel_tap_sequencer.sv
// Bench for sobel_tap_sequencer: MAC model, directed table, reset abort, back-to-back random windows.
module tb_sobel_tap_sequencer;
  localparam int MAC_LAT = 1;
  localparam int LAT     = 2 * (7 + MAC_LAT);
  localparam int PERIOD  = LAT + 2;

  logic        clock;
  logic        IRSTTOP;
  logic        in_valid;
  logic        in_ready;
  logic [71:0] win_i;
  logic [15:0] mac_a, mac_b, mac_c;
  logic        mac_oload, mac_sub, mac_ohold;
  logic [15:0] mac_o;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] gx_o, gy_o;
  logic [7:0]  mag_o;
  logic [2:0]  dbg_state_o;

  int n_tests = 0;
  int n_fail  = 0;

  sobel_tap_sequencer #(.MAC_LAT(MAC_LAT)) dut (
    .clock(clock), .IRSTTOP(IRSTTOP),
    .in_valid(in_valid), .in_ready(in_ready), .win_i(win_i),
    .mac_a(mac_a), .mac_b(mac_b), .mac_c(mac_c),
    .mac_oload(mac_oload), .mac_sub(mac_sub), .mac_ohold(mac_ohold),
    .mac_o(mac_o),
    .out_valid(out_valid), .out_ready(out_ready),
    .gx_o(gx_o), .gy_o(gy_o), .mag_o(mag_o),
    .dbg_state_o(dbg_state_o)
  );

  // ---------------- clock / reset ----------------
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // ---------------- SB_MAC16 accumulator model ----------------
  logic [15:0] acc = 16'd0;
  always @(posedge clock) begin
    if (mac_oload)       acc <= mac_c;
    else if (!mac_ohold) acc <= mac_sub ? acc - 16'(mac_a * mac_b) : acc + 16'(mac_a * mac_b);
  end
  assign mac_o = acc;

  // ---------------- reference model ----------------
  function automatic void sobel_ref(input logic [71:0] w, output int gx, output int gy);
    int kx[9] = '{-1, 0, 1, -2, 0, 2, -1, 0, 1};
    int ky[9] = '{-1, -2, -1, 0, 0, 0, 1, 2, 1};
    gx = 0;
    gy = 0;
    for (int i = 0; i < 9; i++) begin
      gx += kx[i] * int'(w[8*i +: 8]);
      gy += ky[i] * int'(w[8*i +: 8]);
    end
  endfunction

  function automatic logic [7:0] mag_ref(input int gx, input int gy);
    int s;
`ifdef SOBEL_MAG_EN
    s = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
    if (s > 255) s = 255;
`else
    s = gx - gx;
`endif
    return 8'(s);
  endfunction

  function automatic logic [71:0] mk_cols(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
    logic [71:0] w;
    for (int r = 0; r < 3; r++) begin
      w[8*(3*r)   +: 8] = a;
      w[8*(3*r+1) +: 8] = b;
      w[8*(3*r+2) +: 8] = c;
    end
    return w;
  endfunction

  function automatic logic [71:0] mk_rows(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
    logic [71:0] w;
    for (int k = 0; k < 3; k++) begin
      w[8*k     +: 8] = a;
      w[8*(3+k) +: 8] = b;
      w[8*(6+k) +: 8] = c;
    end
    return w;
  endfunction

  function automatic logic [71:0] rand_win();
    logic [71:0] w;
    for (int i = 0; i < 9; i++) w[8*i +: 8] = 8'($urandom_range(0, 255));
    return w;
  endfunction

  // ---------------- driver / check tasks ----------------
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [71:0] win;
    logic [15:0] gx;
    logic [15:0] gy;
    logic [7:0]  mag;
    int          hold;
  } vec_t;

  task automatic run_window(input vec_t v, input string tag);
    int waited;
    int lat;
    in_valid = 1'b1;
    win_i    = v.win;
    waited   = 0;
    while (!in_ready && waited < 50) begin
      tick();
      waited++;
    end
    check({tag, "_in_ready_idle"}, 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    win_i    = rand_win();
    check({tag, "_in_ready_busy"}, 32'(in_ready), 32'd0);
    lat = 0;
    while (!out_valid && lat < 100) begin
      tick();
      lat++;
    end
    check({tag, "_latency"}, 32'(lat), 32'(LAT));
    check({tag, "_gx"}, 32'(gx_o), 32'(v.gx));
    check({tag, "_gy"}, 32'(gy_o), 32'(v.gy));
    check({tag, "_mag"}, 32'(mag_o), 32'(v.mag));
    for (int h = 0; h < v.hold; h++) begin
      tick();
      check({tag, "_hold_valid"}, 32'(out_valid), 32'd1);
      check({tag, "_hold_ready"}, 32'(in_ready), 32'd0);
      check({tag, "_hold_gx"}, 32'(gx_o), 32'(v.gx));
      check({tag, "_hold_gy"}, 32'(gy_o), 32'(v.gy));
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({tag, "_release_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_release_idle"}, 32'(in_ready), 32'd1);
  endtask

  function automatic vec_t model_vec(input logic [71:0] w, input int hold);
    vec_t v;
    int gx, gy;
    sobel_ref(w, gx, gy);
    v.win  = w;
    v.gx   = 16'(gx);
    v.gy   = 16'(gy);
    v.mag  = mag_ref(gx, gy);
    v.hold = hold;
    return v;
  endfunction

  // ---------------- scoreboard ----------------
  logic [39:0] exp_q[$];
  int          acc_cyc[$];

  // ---------------- test sequence ----------------
  initial begin
    vec_t        vecs[8];
    vec_t        rv;
    logic [71:0] w;
    logic [39:0] e;
    int          seen;
    int          cycle;
    int          got;
    int          accepted;
    logic        pending;
    int          gx, gy;
    localparam int N_B2B = 6;

    IRSTTOP   = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    win_i     = 72'd0;
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_gx", 32'(gx_o), 32'd0);
    check("rst_gy", 32'(gy_o), 32'd0);
    check("rst_mag", 32'(mag_o), 32'd0);
    check("rst_mac_a", 32'(mac_a), 32'd0);
    check("rst_mac_b", 32'(mac_b), 32'd0);
    check("rst_mac_oload", 32'(mac_oload), 32'd0);
    check("rst_mac_sub", 32'(mac_sub), 32'd0);
    check("rst_mac_ohold", 32'(mac_ohold), 32'd1);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    repeat (3) @(posedge clock);
    #1;
    IRSTTOP = 1'b0;
    tick();

    // Directed table, then model-checked random windows.
    vecs[0] = '{win: mk_rows(8'd100, 8'd100, 8'd100), gx: 16'h0000, gy: 16'h0000, mag: mag_ref(0, 0),     hold: 0};
    vecs[1] = '{win: mk_cols(8'd0, 8'd50, 8'd100),    gx: 16'h0190, gy: 16'h0000, mag: mag_ref(400, 0),   hold: 0};
    vecs[2] = '{win: mk_rows(8'd0, 8'd0, 8'd255),     gx: 16'h0000, gy: 16'h03FC, mag: mag_ref(0, 1020),  hold: 0};
    vecs[3] = '{win: mk_cols(8'd255, 8'd0, 8'd0),     gx: 16'hFC04, gy: 16'h0000, mag: mag_ref(-1020, 0), hold: 5};
    for (int i = 4; i < 8; i++) vecs[i] = model_vec(rand_win(), $urandom_range(0, 2));
    for (int i = 0; i < 8; i++) run_window(vecs[i], $sformatf("vec%0d", i));

    // Reset in the middle of TAP_Y aborts the window.
    in_valid = 1'b1;
    win_i    = rand_win();
    tick();
    in_valid = 1'b0;
    repeat (11) tick();
    check("abort_in_tap_y", 32'(dbg_state_o), 32'd5);
    check("abort_ohold_before", 32'(mac_ohold), 32'd0);
    IRSTTOP = 1'b1;
    #1;
    check("abort_ohold_now", 32'(mac_ohold), 32'd1);
    check("abort_mac_a", 32'(mac_a), 32'd0);
    check("abort_in_ready", 32'(in_ready), 32'd1);
    tick();
    IRSTTOP   = 1'b0;
    out_ready = 1'b1;
    seen = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (out_valid) seen++;
    end
    check("abort_no_output", 32'(seen), 32'd0);
    out_ready = 1'b0;
    w = mk_cols(8'd0, 8'd10, 8'd20);
    for (int k = 0; k < 3; k++) w[8*k +: 8] = w[8*k +: 8] + 8'd10;
    rv = model_vec(w, 0);
    run_window(rv, "post_abort");
    sobel_ref(w, gx, gy);
    check("post_abort_gx80", 32'(gx), 32'd80);

    // Back-to-back windows with in_valid and out_ready held high.
    out_ready = 1'b1;
    in_valid  = 1'b1;
    win_i     = rand_win();
    cycle     = 0;
    got       = 0;
    accepted  = 0;
    while (got < N_B2B && cycle < 400) begin
      pending = 1'b0;
      if (in_ready && accepted < N_B2B) begin
        sobel_ref(win_i, gx, gy);
        exp_q.push_back({mag_ref(gx, gy), 16'(gx), 16'(gy)});
        acc_cyc.push_back(cycle);
        accepted++;
        pending = 1'b1;
      end
      tick();
      cycle++;
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          check("b2b_unexpected_output", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check($sformatf("b2b%0d_gx", got), 32'(gx_o), 32'(e[31:16]));
          check($sformatf("b2b%0d_gy", got), 32'(gy_o), 32'(e[15:0]));
          check($sformatf("b2b%0d_mag", got), 32'(mag_o), 32'(e[39:32]));
        end
        got++;
      end
      if (pending) begin
        win_i = rand_win();
        if (accepted == N_B2B) in_valid = 1'b0;
      end
    end
    check("b2b_count", 32'(got), 32'(N_B2B));
    check("b2b_queue_empty", 32'(exp_q.size()), 32'd0);
    for (int i = 1; i < acc_cyc.size(); i++)
      check($sformatf("b2b_spacing%0d", i), 32'(acc_cyc[i] - acc_cyc[i-1]), 32'(PERIOD));

    // ---------------- final report ----------------
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
